// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, LSB first, line idles high.
// The rx pin is brought into the clk domain through a 2-flop synchroniser.
// A validated start bit starts the frame, and each bit is then sampled at mid-bit.
// A good byte is reported with a one-cycle data_valid strobe.
// A low stop bit is reported with a one-cycle frame_err strobe.
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   When defined, every sample is the 2-of-3 majority of rx_s at tick 2, 1 and 0.
//   When undefined, every sample is rx_s at tick 0.
//   The decision is taken at tick 0 in both builds, so latency is the same.
//
// Legal only for CLK_FREQ / BAUD_RATE >= 8.
//
// State is observable as state_q (type uart_rx.state_t) for checkers.
module uart_rx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int BIT_TICKS  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_TICKS = BIT_TICKS / 2;

    localparam logic [15:0] BIT_RELOAD  = 16'(BIT_TICKS - 1);
    localparam logic [15:0] HALF_RELOAD = 16'(HALF_TICKS - 1);

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } state_t;

    state_t      state_q;
    logic [1:0]  sync_q;
    logic        rx_s;
    logic [15:0] tick_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic [7:0]  data_out_q;
    logic        data_valid_q;
    logic        frame_err_q;
    logic        busy_q;
    logic        sample_d;

    // Two-flop synchroniser.
    // It resets to the idle (high) level so that reset itself never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    // hist_q[0] holds rx_s from tick 1 and hist_q[1] holds rx_s from tick 2.
    // The counter steps by exactly one each cycle, so this lines up with tick 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign sample_d = (hist_q[1] & hist_q[0]) |
                      (hist_q[1] & rx_s) |
                      (hist_q[0] & rx_s);
`else
    assign sample_d = rx_s;
`endif

    // Receive state machine.
    // The counters, shift register and registered outputs are all updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= WAIT_IDLE;
            tick_q       <= 16'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'd0;
            data_out_q   <= 8'd0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                WAIT_IDLE: begin
                    // A line held low (break, or reset mid-frame) must go high before any start bit.
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (!rx_s) begin
                        tick_q  <= HALF_RELOAD;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (tick_q == 16'd0) begin
                        if (!sample_d) begin
                            tick_q    <= BIT_RELOAD;
                            bit_idx_q <= 3'd0;
                            state_q   <= DATA;
                        end else begin
                            // The line was high again at mid start bit: treat it as a glitch.
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        tick_q <= tick_q - 16'd1;
                    end
                end
                DATA: begin
                    if (tick_q == 16'd0) begin
                        shift_q   <= {sample_d, shift_q[7:1]};
                        tick_q    <= BIT_RELOAD;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        tick_q <= tick_q - 16'd1;
                    end
                end
                STOP: begin
                    if (tick_q == 16'd0) begin
                        busy_q <= 1'b0;
                        if (sample_d) begin
                            data_out_q   <= shift_q;
                            data_valid_q <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_IDLE;
                        end
                    end else begin
                        tick_q <= tick_q - 16'd1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= WAIT_IDLE;
                end
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at BIT_TICKS = 16 and HALF_TICKS = 8.
//
// rx is driven on the falling clock edge.
// A monitor on the falling edge pops the expected queue whenever a strobe appears.
// Each queue entry is {kind, byte}, where kind 1 = data_valid and kind 2 = frame_err.
module tb_uart_rx;

    localparam int W       = 10;
    localparam int NOM_LAT = 155;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    logic [W-1:0] exp_q[$];
    int           t_q[$];
    int           cyc;
    int           total;
    int           bad;

    uart_rx #(
        .CLK_FREQ (16),
        .BAUD_RATE(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    // ---------------- clock / reset block ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && (data_valid || frame_err)) begin
            logic [W-1:0] e;
            int           t;
            int           lat;
            if (data_valid && frame_err) begin
                total++;
                bad++;
                $display("FAIL strobes: data_valid and frame_err both high at cycle %0d", cyc);
            end else if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: valid=%0b ferr=%0b data=%0h at cycle %0d",
                         data_valid, frame_err, data_out, cyc);
            end else begin
                e = exp_q.pop_front();
                t = t_q.pop_front();
                check("strobe_kind", {30'd0, frame_err, data_valid}, {30'd0, e[9:8]});
                if (data_valid) begin
                    check("rx_byte", {24'd0, data_out}, {24'd0, e[7:0]});
                end
                lat = cyc - t;
                total++;
                if (lat < NOM_LAT - 2 || lat > NOM_LAT + 2) begin
                    bad++;
                    $display("FAIL latency: got=%0d expected=%0d+-2", lat, NOM_LAT);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    // kind: 0 = no strobe expected, 1 = data_valid expected, 2 = frame_err expected.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic noise,
                              input logic [1:0] kind, input logic [7:0] exp_b);
        logic v;
        int   f;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            if (c == 0 && kind != 2'd0) begin
                exp_q.push_back({kind, exp_b});
                t_q.push_back(cyc);
            end
            f = c / 16;
            if (f == 0) begin
                v = 1'b0;
            end else if (f <= 8) begin
                v = b[f-1];
            end else begin
                v = stop_bit;
            end
            if (noise && f >= 1 && f <= 8 && (c % 16) == 8) begin
                v = ~v;
            end
            rx = v;
            if (c == 80) begin
                check("busy_mid_frame", {31'd0, busy}, 32'd1);
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d expected strobes never seen", exp_q.size());
            exp_q.delete();
            t_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic [1:0] exp_kind;
        logic [7:0] exp_data_out;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] noise_exp;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        rx    = 1'b1;

        vecs[0] = '{data: 8'hA5, stop_bit: 1'b1, exp_kind: 2'd1, exp_data_out: 8'hA5};
        vecs[1] = '{data: 8'h5A, stop_bit: 1'b1, exp_kind: 2'd1, exp_data_out: 8'h5A};
        vecs[2] = '{data: 8'h55, stop_bit: 1'b0, exp_kind: 2'd2, exp_data_out: 8'h5A};
        vecs[3] = '{data: 8'h01, stop_bit: 1'b1, exp_kind: 2'd1, exp_data_out: 8'h01};
        vecs[4] = '{data: 8'h80, stop_bit: 1'b1, exp_kind: 2'd1, exp_data_out: 8'h80};
        vecs[5] = '{data: 8'hFF, stop_bit: 1'b0, exp_kind: 2'd2, exp_data_out: 8'h80};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_data_out", {24'd0, data_out}, 32'd0);
        check("reset_valid", {31'd0, data_valid}, 32'd0);
        check("reset_ferr", {31'd0, frame_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        idle(10);

        // Table: good frames and framing errors.
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].stop_bit, 1'b0, vecs[i].exp_kind, vecs[i].data);
            if (!vecs[i].stop_bit) begin
                // Hold the line low; it must not be mistaken for a start bit.
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    rx = 1'b0;
                end
                check("busy_line_low", {31'd0, busy}, 32'd0);
            end
            idle(20);
            wait_drain();
            check("data_out_after", {24'd0, data_out}, {24'd0, vecs[i].exp_data_out});
        end

        // Back-to-back frames with no idle gap; latency check enforces 160-cycle spacing.
        send_frame(8'h00, 1'b1, 1'b0, 2'd1, 8'h00);
        send_frame(8'hFF, 1'b1, 1'b0, 2'd1, 8'hFF);
        send_frame(8'h3C, 1'b1, 1'b0, 2'd1, 8'h3C);
        idle(20);
        wait_drain();
        check("b2b_last", {24'd0, data_out}, 32'h3C);

        // Start glitch: 4 low cycles only.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rx = 1'b0;
        end
        idle(30);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        check("glitch_data_out", {24'd0, data_out}, 32'h3C);
        send_frame(8'h12, 1'b1, 1'b0, 2'd1, 8'h12);
        idle(20);
        wait_drain();

        // Reset in the middle of data bit 4 of 0x81.
        // rst stays high until the stop bit.
        for (int c = 0; c < 160; c++) begin
            int f;
            logic [7:0] b;
            b = 8'h81;
            @(negedge clk);
            f = c / 16;
            rx = (f == 0) ? 1'b0 : (f <= 8) ? b[f-1] : 1'b1;
            if (c == 88) begin
                check("pre_reset_busy", {31'd0, busy}, 32'd1);
                rst = 1'b1;
                #1;
                check("midrst_data_out", {24'd0, data_out}, 32'd0);
                check("midrst_valid", {31'd0, data_valid}, 32'd0);
                check("midrst_ferr", {31'd0, frame_err}, 32'd0);
                check("midrst_busy", {31'd0, busy}, 32'd0);
            end
            if (c == 150) begin
                rst = 1'b0;
            end
        end
        idle(30);
        check("post_reset_data_out", {24'd0, data_out}, 32'd0);
        check("post_reset_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h7E, 1'b1, 1'b0, 2'd1, 8'h7E);
        idle(20);
        wait_drain();

        // Noise pulse at every data-bit sample point.
        // The majority build recovers the byte; the single-sample build reads every data bit inverted.
`ifdef UART_RX_MAJORITY_EN
        noise_exp = 8'hC3;
`else
        noise_exp = 8'h3C;
`endif
        send_frame(8'hC3, 1'b1, 1'b1, 2'd1, noise_exp);
        idle(20);
        wait_drain();

        idle(50);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
